mdu_pipe_controller: RTL
========================

# mdu_pipe_controller

Parametrised successor of the pipelined MIPS controller. Decodes an extended ISA (adds bne, immediate ALU ops, jal, jr, mult/div, mfhi/mflo), carries control through E/M/W with per-stage stall and flush, and owns a multi-cycle multiply/divide sequencer that requests decode stalls while busy. Sits between the hazard unit and the datapath.

## Interface
- MDU_LATENCY, 8, cycles mult/div occupies the MDU (≥2)
- ALUCTL_W, 4, alucontrol width (≥4)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- opD, functD  in  6 each  instruction fields in D
- equalD  in  1  register compare result in D
- stallE  in  1  hold E stage, bubble into M
- flushE, flushM  in  1 each  clear E / M stage
- pcsrcD, branchD, jumpD, jumpregD, illegalD  out  1 each  D-stage combinational decode
- mdu_stallD  out  1  D-stage MDU hazard request
- alusrcE, zeroextE, memtoregE, regwriteE, mdu_startE  out  1 each
- regdstE  out  2  00 rt, 01 rd, 10 r31
- alucontrolE  out  ALUCTL_W  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
- memtoregM, memwriteM, regwriteM, linkM  out  1 each
- memtoregW, regwriteW, linkW, hiloselW  out  1 each (hiloselW: 0 none, else mfhi/mflo result source)
- mdu_busy, mdu_done  out  1 each

## Operation
- Decode (combinational, opD): 000000 R-type; 100011 lw (regwrite, alusrc, memtoreg, add); 101011 sw (memwrite, alusrc, add); 000100 beq, 000101 bne (branchD); 001000 addi (add); 001100 andi, 001101 ori (zeroext); 001010 slti (slt); 000010 j; 000011 jal (jump, regwrite, regdst=10, link). Any other opD: all controls 0, illegalD=1.
- R-type functD: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (regwrite, regdst=01); 001000 jr (jumpregD, no regwrite); 011000 mult, 011010 div (mdu start, no regwrite); 010000 mfhi, 010010 mflo (regwrite, regdst=01, hilosel). Unknown funct: controls 0, illegalD=1.
- pcsrcD = (beq & equalD) | (bne & ~equalD).
- E register: flushE → clear (priority over stallE); else stallE → hold; else load D bundle.
- M register: flushM or stallE → clear; else load E bundle. W register always loads M.
- MDU FSM states IDLE, BUSY. IDLE & mdu_startE & ~stallE → BUSY, count=MDU_LATENCY-1. BUSY: count decrements each cycle; at count==0 → IDLE with mdu_done=1 for that cycle. mdu_startE while BUSY ignored (hazard unit must prevent it).
- mdu_busy=1 in BUSY. mdu_stallD = mdu_busy & (D is mult/div/mfhi/mflo).
- flushE/flushM never abort a running MDU operation.

## Timing
- Async reset (reset=0): every E/M/W output 0, FSM IDLE, count 0, mdu_busy=0, mdu_done=0. Reset mid-MDU operation aborts it; no mdu_done.
- D outputs combinational, zero latency. Unstalled instruction reaches E 1 cycle after D, M at 2, W at 3.
- mult issued in E at cycle t (not stalled): mdu_busy=1 cycles t+1..t+MDU_LATENCY, mdu_done=1 in cycle t+MDU_LATENCY, idle from t+MDU_LATENCY+1.
- stallE held N cycles: E outputs frozen N cycles; M receives N bubbles.
- Simultaneous flushE & stallE: E cleared, M gets bubble.

## Test plan
- Reset mid-flow: lw in flight, drive reset=0 → all E/M/W outputs 0, mdu_busy=0 immediately, before next clk edge.
- Decode sweep: each listed op/funct plus opD=111111 → E-stage bundle matches table one cycle later; 111111 gives illegalD=1, all controls 0.
- Branches: beq equalD=1 → pcsrcD=1; bne equalD=1 → 0; bne equalD=0 → 1.
- jal through pipe: regdstE=10 at t+1, linkM=1 at t+2, linkW=1 & regwriteW=1 at t+3.
- MDU, MDU_LATENCY=8: mult in E at t → busy t+1..t+8, done at t+8; mflo in D during busy → mdu_stallD=1; add in D → 0.
- stallE=1 two cycles with sw in E → memwriteM=0 both cycles, memwriteM=1 cycle after release; flushE with stallE → E cleared.

Source files
------------

// File: rtl/mdu_pipe_controller.sv
// mdu_pipe_controller
// Pipelined MIPS control unit for an extended ISA. It decodes in D, carries the
// control bundle through E/M/W with stall/flush handling, and sequences a
// multi-cycle multiply/divide unit. While that unit is busy, the controller
// asks D to stall any instruction that touches HI/LO.
module mdu_pipe_controller #(
  parameter int MDU_LATENCY = 8,
  parameter int ALUCTL_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opD,
  input  logic [5:0]          functD,
  input  logic                equalD,
  input  logic                stallE,
  input  logic                flushE,
  input  logic                flushM,
  output logic                pcsrcD,
  output logic                branchD,
  output logic                jumpD,
  output logic                jumpregD,
  output logic                illegalD,
  output logic                mdu_stallD,
  output logic                alusrcE,
  output logic                zeroextE,
  output logic                memtoregE,
  output logic                regwriteE,
  output logic                mdu_startE,
  output logic [1:0]          regdstE,
  output logic [ALUCTL_W-1:0] alucontrolE,
  output logic                memtoregM,
  output logic                memwriteM,
  output logic                regwriteM,
  output logic                linkM,
  output logic                memtoregW,
  output logic                regwriteW,
  output logic                linkW,
  output logic                hiloselW,
  output logic                mdu_busy,
  output logic                mdu_done
);

  // A latency of 2 or more keeps the reload value nonzero, so the counter
  // never reaches zero in the same cycle it is loaded.
  localparam int CNT_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(4'b0000);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(4'b0001);
  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(4'b0010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(4'b0110);
  localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(4'b0111);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MDU_LATENCY - 1);

  typedef struct packed {
    logic                alusrc;
    logic                zeroext;
    logic                memtoreg;
    logic                memwrite;
    logic                regwrite;
    logic                mdu_start;
    logic                link;
    logic                hilosel;
    logic [1:0]          regdst;
    logic [ALUCTL_W-1:0] alucontrol;
  } ctrl_e_t;

  typedef struct packed {
    logic memtoreg;
    logic memwrite;
    logic regwrite;
    logic link;
    logic hilosel;
  } ctrl_m_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic link;
    logic hilosel;
  } ctrl_w_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  ctrl_e_t    ctrl_d_s;
  logic       beq_s;
  logic       bne_s;
  logic       jump_s;
  logic       jumpreg_s;
  logic       illegal_s;
  logic       is_mdu_op_s;

  ctrl_e_t    ctrl_e_d, ctrl_e_q;
  ctrl_m_t    ctrl_m_d, ctrl_m_q;
  ctrl_w_t    ctrl_w_d, ctrl_w_q;

  mdu_state_t state_d, state_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic       done_d, done_q;

  // D-stage decode of opcode/funct into the control bundle and branch/jump flags
  always_comb begin
    ctrl_d_s    = '0;
    beq_s       = 1'b0;
    bne_s       = 1'b0;
    jump_s      = 1'b0;
    jumpreg_s   = 1'b0;
    illegal_s   = 1'b0;
    is_mdu_op_s = 1'b0;
    case (opD)
      6'b000000: begin
        case (functD)
          6'b100000: begin ctrl_d_s.regwrite = 1'b1; ctrl_d_s.regdst = 2'b01; ctrl_d_s.alucontrol = ALU_ADD; end
          6'b100010: begin ctrl_d_s.regwrite = 1'b1; ctrl_d_s.regdst = 2'b01; ctrl_d_s.alucontrol = ALU_SUB; end
          6'b100100: begin ctrl_d_s.regwrite = 1'b1; ctrl_d_s.regdst = 2'b01; ctrl_d_s.alucontrol = ALU_AND; end
          6'b100101: begin ctrl_d_s.regwrite = 1'b1; ctrl_d_s.regdst = 2'b01; ctrl_d_s.alucontrol = ALU_OR;  end
          6'b101010: begin ctrl_d_s.regwrite = 1'b1; ctrl_d_s.regdst = 2'b01; ctrl_d_s.alucontrol = ALU_SLT; end
          6'b001000: jumpreg_s = 1'b1;
          6'b011000, 6'b011010: begin
            ctrl_d_s.mdu_start = 1'b1;
            is_mdu_op_s        = 1'b1;
          end
          6'b010000, 6'b010010: begin
            ctrl_d_s.regwrite = 1'b1;
            ctrl_d_s.regdst   = 2'b01;
            ctrl_d_s.hilosel  = 1'b1;
            is_mdu_op_s       = 1'b1;
          end
          default: illegal_s = 1'b1;
        endcase
      end
      6'b100011: begin
        ctrl_d_s.regwrite   = 1'b1;
        ctrl_d_s.alusrc     = 1'b1;
        ctrl_d_s.memtoreg   = 1'b1;
        ctrl_d_s.alucontrol = ALU_ADD;
      end
      6'b101011: begin
        ctrl_d_s.memwrite   = 1'b1;
        ctrl_d_s.alusrc     = 1'b1;
        ctrl_d_s.alucontrol = ALU_ADD;
      end
      6'b000100: beq_s = 1'b1;
      6'b000101: bne_s = 1'b1;
      6'b001000: begin ctrl_d_s.regwrite = 1'b1; ctrl_d_s.alusrc = 1'b1; ctrl_d_s.alucontrol = ALU_ADD; end
      6'b001100: begin
        ctrl_d_s.regwrite = 1'b1; ctrl_d_s.alusrc = 1'b1; ctrl_d_s.zeroext = 1'b1; ctrl_d_s.alucontrol = ALU_AND;
      end
      6'b001101: begin
        ctrl_d_s.regwrite = 1'b1; ctrl_d_s.alusrc = 1'b1; ctrl_d_s.zeroext = 1'b1; ctrl_d_s.alucontrol = ALU_OR;
      end
      6'b001010: begin ctrl_d_s.regwrite = 1'b1; ctrl_d_s.alusrc = 1'b1; ctrl_d_s.alucontrol = ALU_SLT; end
      6'b000010: jump_s = 1'b1;
      6'b000011: begin
        jump_s            = 1'b1;
        ctrl_d_s.regwrite = 1'b1;
        ctrl_d_s.regdst   = 2'b10;
        ctrl_d_s.link     = 1'b1;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign branchD    = beq_s | bne_s;
  assign pcsrcD     = (beq_s & equalD) | (bne_s & ~equalD);
  assign jumpD      = jump_s;
  assign jumpregD   = jumpreg_s;
  assign illegalD   = illegal_s;
  assign mdu_stallD = mdu_busy & is_mdu_op_s;

  // Next E/M/W bundles: flushE beats stallE; a stalled E sends a bubble into M
  always_comb begin
    ctrl_e_d = ctrl_e_q;
    if (flushE) begin
      ctrl_e_d = '0;
    end else if (stallE) begin
      ctrl_e_d = ctrl_e_q;
    end else begin
      ctrl_e_d = ctrl_d_s;
    end

    ctrl_m_d = '0;
    if (flushM || stallE) begin
      ctrl_m_d = '0;
    end else begin
      ctrl_m_d.memtoreg = ctrl_e_q.memtoreg;
      ctrl_m_d.memwrite = ctrl_e_q.memwrite;
      ctrl_m_d.regwrite = ctrl_e_q.regwrite;
      ctrl_m_d.link     = ctrl_e_q.link;
      ctrl_m_d.hilosel  = ctrl_e_q.hilosel;
    end

    ctrl_w_d.memtoreg = ctrl_m_q.memtoreg;
    ctrl_w_d.regwrite = ctrl_m_q.regwrite;
    ctrl_w_d.link     = ctrl_m_q.link;
    ctrl_w_d.hilosel  = ctrl_m_q.hilosel;
  end

  // Pipeline control registers E/M/W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
    end
  end

  // MDU sequencer next state: start from IDLE, count down in BUSY, and flag done on the last busy cycle
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      MDU_IDLE: begin
        if (ctrl_e_q.mdu_start && !stallE) begin
          state_d = MDU_BUSY;
          count_d = CNT_RELOAD;
        end else begin
          state_d = MDU_IDLE;
        end
      end
      MDU_BUSY: begin
        if (count_q == {CNT_W{1'b0}}) begin
          state_d = MDU_IDLE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MDU_IDLE;
        count_d = {CNT_W{1'b0}};
      end
    endcase
    done_d = (state_d == MDU_BUSY) && (count_d == {CNT_W{1'b0}});
  end

  // MDU sequencer registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      count_q <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign mdu_busy = (state_q == MDU_BUSY);
  assign mdu_done = done_q;

  assign alusrcE     = ctrl_e_q.alusrc;
  assign zeroextE    = ctrl_e_q.zeroext;
  assign memtoregE   = ctrl_e_q.memtoreg;
  assign regwriteE   = ctrl_e_q.regwrite;
  assign mdu_startE  = ctrl_e_q.mdu_start;
  assign regdstE     = ctrl_e_q.regdst;
  assign alucontrolE = ctrl_e_q.alucontrol;

  assign memtoregM = ctrl_m_q.memtoreg;
  assign memwriteM = ctrl_m_q.memwrite;
  assign regwriteM = ctrl_m_q.regwrite;
  assign linkM     = ctrl_m_q.link;

  assign memtoregW = ctrl_w_q.memtoreg;
  assign regwriteW = ctrl_w_q.regwrite;
  assign linkW     = ctrl_w_q.link;
  assign hiloselW  = ctrl_w_q.hilosel;

endmodule
